// File: rtl/processors_result_collector_pkg.sv
// Shared definitions for the processor array, its controller and the result collector.
// Holds the array geometry, the per-pass result bundle type and the collector states.
package processors_result_collector_pkg;

   localparam int unsigned RESULT_WORD_LENGHT = 16;
   localparam int unsigned NUM_PROCESSORS     = 4;

   // Element k holds the result of processor k+1.
   typedef logic [NUM_PROCESSORS-1:0][RESULT_WORD_LENGHT-1:0] processor_result_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_CAP = 2'd1,
      DRAIN    = 2'd2,
      DONE     = 2'd3
   } collector_state_e;

endpackage

// File: rtl/processors_result_collector_result_skid_mux.sv
// Per-pass result buffer plus the registered index mux that presents one word at a time.
// The output register is loaded directly from the incoming bundle on capture.
module result_skid_mux #(
   parameter int unsigned WORD_LENGHT = 16,
   parameter int unsigned NUM_PROC    = 4,
   localparam int unsigned IDX_W      = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 load,
   input  logic [NUM_PROC-1:0][WORD_LENGHT-1:0] load_data,
   input  logic                                 advance,
   input  logic [IDX_W-1:0]                     sel,
   output logic [WORD_LENGHT-1:0]               out_data
);

   logic [NUM_PROC-1:0][WORD_LENGHT-1:0] buf_q;
   logic [WORD_LENGHT-1:0]               out_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q <= '0;
         out_q <= '0;
      end else if (load) begin
         buf_q <= load_data;
         out_q <= load_data[0];
      end else if (advance) begin
         out_q <= buf_q[sel];
      end
   end

   assign out_data = out_q;

endmodule

// File: rtl/processors_result_collector.sv
// Latches each processor-array result bundle and drains the valid row results over a
// valid/ready stream, tracking outstanding rows and pulsing done at job end.
module processors_result_collector
   import processors_result_collector_pkg::*;
#(
   parameter int unsigned WORD_LENGHT = RESULT_WORD_LENGHT,
   parameter int unsigned NUM_PROC    = NUM_PROCESSORS
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [3:0]                           N,
   input  logic                                 capture,
   input  logic [NUM_PROC-1:0][WORD_LENGHT-1:0] result,
   output logic [WORD_LENGHT-1:0]               out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 overrun
);

   localparam int unsigned     IDX_W     = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
   localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(NUM_PROC - 1);

   collector_state_e state_q, state_d;
   logic [3:0]       remaining_q, remaining_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic             out_valid_q, out_valid_d;
   logic             overrun_q, overrun_d;
   logic             handshake;
   logic             load;
   logic             advance;
   logic [IDX_W-1:0] next_idx;

   assign handshake = out_valid_q & out_ready;
   assign next_idx  = idx_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      idx_d       = idx_q;
      last_d      = last_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;
      load        = 1'b0;
      advance     = 1'b0;

      // A capture is only expected in WAIT_CAP; an idle array may still pulse it harmlessly.
      if (capture && (state_q != WAIT_CAP) && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               remaining_d = N;
               overrun_d   = 1'b0;
               state_d     = (N == 4'd0) ? DONE : WAIT_CAP;
            end
         end
         WAIT_CAP: begin
            if (capture) begin
               load        = 1'b1;
               idx_d       = '0;
               out_valid_d = 1'b1;
               state_d     = DRAIN;
               if (int'(remaining_q) >= int'(NUM_PROC)) begin
                  last_d = LAST_FULL;
               end else begin
                  last_d = IDX_W'(remaining_q - 4'd1);
               end
            end
         end
         DRAIN: begin
            if (handshake) begin
               remaining_d = remaining_q - 4'd1;
               idx_d       = next_idx;
               if (idx_q == last_q) begin
                  out_valid_d = 1'b0;
                  state_d     = (remaining_q == 4'd1) ? DONE : WAIT_CAP;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         idx_q       <= '0;
         last_q      <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   result_skid_mux #(
      .WORD_LENGHT (WORD_LENGHT),
      .NUM_PROC    (NUM_PROC)
   ) u_skid_mux (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_data (result),
      .advance   (advance),
      .sel       (next_idx),
      .out_data  (out_data)
   );

   assign out_valid = out_valid_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_processors_result_collector.sv
// Directed bench for processors_result_collector: single row, multi-pass with
// backpressure, empty job, overrun, mid-job reset and start-while-busy.
module tb_processors_result_collector;

   logic             clk;
   logic             reset;
   logic             start;
   logic [3:0]       N;
   logic             capture;
   logic [3:0][15:0] result;
   logic [15:0]      out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic             overrun;

   int n_checks = 0;
   int n_fail   = 0;

   processors_result_collector #(
      .WORD_LENGHT (16),
      .NUM_PROC    (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .N         (N),
      .capture   (capture),
      .result    (result),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_result(input int a, input int b, input int c, input int d);
      result[0] = 16'(a);
      result[1] = 16'(b);
      result[2] = 16'(c);
      result[3] = 16'(d);
   endtask

   task automatic do_start(input logic [3:0] n);
      start = 1'b1;
      N     = n;
      tick();
      start = 1'b0;
   endtask

   task automatic do_capture();
      capture = 1'b1;
      tick();
      capture = 1'b0;
   endtask

   // Each word is checked, stalled for one cycle and rechecked, then accepted.
   task automatic drain_batch(input int cnt, input int base, input string tag);
      for (int i = 0; i < cnt; i++) begin
         chk({tag, "_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_data"}, 32'(out_data), 32'(base + i));
         chk({tag, "_nodone"}, 32'(done), 32'd0);
         out_ready = 1'b0;
         tick();
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_data"}, 32'(out_data), 32'(base + i));
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      N         = 4'd0;
      capture   = 1'b0;
      out_ready = 1'b0;
      set_result(0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);

      // Single row: only the first word of the bundle is presented.
      do_start(4'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_wait_valid", 32'(out_valid), 32'd0);
      set_result(1, 2, 3, 4);
      do_capture();
      drain_batch(1, 1, "t1");
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_done_valid", 32'(out_valid), 32'd0);
      chk("t1_done_busy", 32'(busy), 32'd1);
      tick();
      chk("t1_after_done", 32'(done), 32'd0);
      chk("t1_after_busy", 32'(busy), 32'd0);
      chk("t1_after_valid", 32'(out_valid), 32'd0);

      // Multi-pass with backpressure: 10..13 then 20,21.
      do_start(4'd6);
      set_result(10, 11, 12, 13);
      do_capture();
      drain_batch(4, 10, "t2a");
      chk("t2_gap_valid", 32'(out_valid), 32'd0);
      chk("t2_gap_busy", 32'(busy), 32'd1);
      chk("t2_gap_done", 32'(done), 32'd0);
      set_result(20, 21, 22, 23);
      do_capture();
      drain_batch(2, 20, "t2b");
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_done_valid", 32'(out_valid), 32'd0);
      tick();
      chk("t2_after_done", 32'(done), 32'd0);
      chk("t2_after_busy", 32'(busy), 32'd0);

      // Empty job goes straight to DONE.
      do_start(4'd0);
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_busy", 32'(busy), 32'd1);
      chk("t3_valid", 32'(out_valid), 32'd0);
      tick();
      chk("t3_after_done", 32'(done), 32'd0);
      chk("t3_after_busy", 32'(busy), 32'd0);
      chk("t3_after_valid", 32'(out_valid), 32'd0);

      // Capture while idle is ignored without flagging overrun.
      set_result(99, 98, 97, 96);
      do_capture();
      chk("idle_cap_overrun", 32'(overrun), 32'd0);
      chk("idle_cap_busy", 32'(busy), 32'd0);
      chk("idle_cap_valid", 32'(out_valid), 32'd0);

      // Overrun: second capture during DRAIN leaves the buffer intact.
      do_start(4'd8);
      set_result(30, 31, 32, 33);
      do_capture();
      set_result(40, 41, 42, 43);
      do_capture();
      chk("t4_overrun", 32'(overrun), 32'd1);
      chk("t4_data_kept", 32'(out_data), 32'd30);
      drain_batch(4, 30, "t4a");
      chk("t4_gap_valid", 32'(out_valid), 32'd0);
      set_result(50, 51, 52, 53);
      do_capture();
      drain_batch(4, 50, "t4b");
      chk("t4_done", 32'(done), 32'd1);
      tick();
      chk("t4_sticky", 32'(overrun), 32'd1);
      chk("t4_idle", 32'(busy), 32'd0);
      do_start(4'd1);
      chk("t4_clear", 32'(overrun), 32'd0);
      set_result(60, 61, 62, 63);
      do_capture();
      drain_batch(1, 60, "t4c");
      chk("t4c_done", 32'(done), 32'd1);
      tick();

      // Reset mid-job clears everything; a fresh job then runs normally.
      do_start(4'd3);
      set_result(70, 71, 72, 73);
      do_capture();
      chk("t5_valid_pre", 32'(out_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_data", 32'(out_data), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_overrun", 32'(overrun), 32'd0);
      do_start(4'd2);
      set_result(80, 81, 82, 83);
      do_capture();
      drain_batch(2, 80, "t5b");
      chk("t5b_done", 32'(done), 32'd1);
      tick();
      chk("t5b_after", 32'(busy), 32'd0);

      // Start while busy is ignored: exactly three words.
      do_start(4'd3);
      do_start(4'd5);
      set_result(90, 91, 92, 93);
      do_capture();
      drain_batch(3, 90, "t6");
      chk("t6_done", 32'(done), 32'd1);
      chk("t6_valid", 32'(out_valid), 32'd0);
      tick();
      chk("t6_after_done", 32'(done), 32'd0);
      chk("t6_after_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
